psum_bitserial_accumulator: RTL and testbench

Sits directly downstream of the 8-to-1 signed adder tree in the BitNet CiM datapath.
- Consumes one 16-bit signed partial sum per accepted beat. Each beat is the ternary-weight dot product of one activation bit-plane.
- Shift-accumulates the bit-planes (LSB first) and then the row tiles into one wide accumulator.
- Emits one saturated output word per configured job over a valid/ready handshake.

---
 rtl/psum_bitserial_accumulator.sv | 154 +++++++++++++++
 tb/tb_psum_bitserial_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_bitserial_accumulator.sv
// psum_bitserial_accumulator
// Shift-accumulates signed bit-plane partial sums from the adder tree
// (LSB plane first, then row tiles) into a wide accumulator. It emits one
// saturated result per job over a valid/ready handshake.
module psum_bitserial_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 24,
    parameter int MAX_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [3:0]                  cfg_bits,
    input  logic [7:0]                  cfg_tiles,
    input  logic                        cfg_signed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_psum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_sat,
    output logic                        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_BITS = 4'(MAX_BITS);

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [3:0]                    r_bits;
    logic [7:0]                    r_tiles;
    logic                          r_signed;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic [3:0]                    r_bit_idx;
    logic [7:0]                    r_tile_idx;
    logic signed [OUT_WIDTH-1:0]   r_out_data;
    logic                          r_out_sat;

    logic                          w_beat;
    logic                          w_bit_last;
    logic                          w_last;
    logic signed [ACC_WIDTH-1:0]   w_ext;
    logic signed [ACC_WIDTH-1:0]   w_shift;
    logic signed [ACC_WIDTH-1:0]   w_term;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic [OUT_WIDTH:0]            w_sat;

    // Bit-planes per tile: 0 behaves as 1, anything above MAX_BITS is capped.
    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b == 4'd0)
            clamp_bits = 4'd1;
        else if (b > LP_MAX_BITS)
            clamp_bits = LP_MAX_BITS;
        else
            clamp_bits = b;
    endfunction

    // Tiles per job: 0 behaves as 1.
    function automatic logic [7:0] clamp_tiles(input logic [7:0] t);
        clamp_tiles = (t == 8'd0) ? 8'd1 : t;
    endfunction

    // Returns {sat_flag, clipped_word}. The value fits the output width
    // exactly when every bit from the output sign bit upward agrees.
    function automatic logic [OUT_WIDTH:0] sat_word(input logic signed [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-OUT_WIDTH:0] hi;
        hi = v[ACC_WIDTH-1:OUT_WIDTH-1];
        if (hi == '0 || hi == '1)
            sat_word = {1'b0, v[OUT_WIDTH-1:0]};
        else if (v[ACC_WIDTH-1])
            sat_word = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_word = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    // Handshake and term datapath
    assign in_ready   = (r_state == S_ACCUM);
    assign out_valid  = (r_state == S_OUTPUT);
    assign busy       = (r_state != S_IDLE);
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;

    assign w_beat     = in_valid && in_ready;
    assign w_bit_last = (r_bit_idx == (r_bits - 4'd1));
    assign w_last     = w_bit_last && (r_tile_idx == (r_tiles - 8'd1));

    // The MSB plane of a two's-complement activation carries negative weight.
    assign w_ext      = {{(ACC_WIDTH-IN_WIDTH){in_psum[IN_WIDTH-1]}}, in_psum};
    assign w_shift    = w_ext <<< r_bit_idx;
    assign w_term     = (r_signed && w_bit_last) ? -w_shift : w_shift;
    assign w_sum      = r_acc + w_term;
    assign w_sat      = sat_word(w_sum);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: start only matters in IDLE, the last beat ends ACCUM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)           w_state_nxt = S_ACCUM;
            S_ACCUM:  if (w_beat && w_last) w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (out_ready)       w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Job configuration, accumulator, plane/tile counters and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits     <= 4'd1;
            r_tiles    <= 8'd1;
            r_signed   <= 1'b0;
            r_acc      <= '0;
            r_bit_idx  <= '0;
            r_tile_idx <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_bits     <= clamp_bits(cfg_bits);
            r_tiles    <= clamp_tiles(cfg_tiles);
            r_signed   <= cfg_signed;
            r_acc      <= '0;
            r_bit_idx  <= '0;
            r_tile_idx <= '0;
        end else if (w_beat) begin
            r_acc <= w_sum;
            if (w_bit_last) begin
                r_bit_idx  <= '0;
                r_tile_idx <= r_tile_idx + 8'd1;
            end else begin
                r_bit_idx  <= r_bit_idx + 4'd1;
            end
            if (w_last) begin
                r_out_data <= w_sat[OUT_WIDTH-1:0];
                r_out_sat  <= w_sat[OUT_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_psum_bitserial_accumulator.sv
// Self-checking bench for psum_bitserial_accumulator: directed jobs plus
// randomized jobs, compared against an arithmetic reference model.
module tb_psum_bitserial_accumulator;

    localparam int IN_W  = 16;
    localparam int OUT_W = 24;
    localparam int MAXB  = 8;
    localparam longint OUT_MAX = 64'sd8388607;
    localparam longint OUT_MIN = -64'sd8388608;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [3:0]              cfg_bits;
    logic [7:0]              cfg_tiles;
    logic                    cfg_signed;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_psum;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic                    busy;

    int n_checks = 0;
    int n_err    = 0;
    int q_psum[$];

    always #5 clk = ~clk;

    psum_bitserial_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_bits   (cfg_bits),
        .cfg_tiles  (cfg_tiles),
        .cfg_signed (cfg_signed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_psum    (in_psum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int eff_bits(input int cb);
        return (cb == 0) ? 1 : ((cb > MAXB) ? MAXB : cb);
    endfunction

    function automatic int eff_tiles(input int ct);
        return (ct == 0) ? 1 : ct;
    endfunction

    // Result = sum over tiles and planes of psum * 2^plane, MSB plane weighted
    // negatively for signed activations; then clipped to the output range.
    task automatic model(input int cb, input int ct, input int cs,
                         output longint d, output logic s);
        longint acc;
        longint term;
        int     k;
        acc = 0;
        k   = 0;
        for (int t = 0; t < eff_tiles(ct); t++) begin
            for (int b = 0; b < eff_bits(cb); b++) begin
                term = longint'(q_psum[k]) * (longint'(1) << b);
                if (cs != 0 && b == eff_bits(cb) - 1) term = -term;
                acc += term;
                k++;
            end
        end
        if (acc > OUT_MAX) begin
            d = OUT_MAX; s = 1'b1;
        end else if (acc < OUT_MIN) begin
            d = OUT_MIN; s = 1'b1;
        end else begin
            d = acc; s = 1'b0;
        end
    endtask

    // One complete job: start, beats with bubbles (bub<0 means random 0..2),
    // hold cycles of backpressure with ignored starts, then the handshake.
    task automatic run_job(input string tag, input int cb, input int ct, input int cs,
                           input int bub, input int hold);
        longint exp_d;
        logic   exp_s;
        int     n;
        int     nb;
        int     junk;
        n = eff_bits(cb) * eff_tiles(ct);
        model(cb, ct, cs, exp_d, exp_s);

        @(negedge clk);
        start      = 1'b1;
        cfg_bits   = cb[3:0];
        cfg_tiles  = ct[7:0];
        cfg_signed = cs[0];
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);

        for (int i = 0; i < n; i++) begin
            nb = (bub < 0) ? int'($urandom_range(0, 2)) : bub;
            for (int j = 0; j < nb; j++) begin
                in_valid   = 1'b0;
                junk       = int'($urandom);
                in_psum    = junk[15:0];
                start      = junk[16];
                cfg_bits   = junk[20:17];
                cfg_tiles  = junk[28:21];
                @(negedge clk);
            end
            start = 1'b0;
            check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            check({tag, "_no_early_valid"}, 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            in_psum  = q_psum[i][15:0];
            @(negedge clk);
        end
        in_valid = 1'b0;

        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out_data"},  64'($signed(out_data)), exp_d);
        check({tag, "_out_sat"},   64'(out_sat), 64'(exp_s));
        check({tag, "_in_ready_out"}, 64'(in_ready), 64'd0);

        for (int h = 0; h < hold; h++) begin
            start     = 1'b1;
            cfg_bits  = 4'($urandom);
            cfg_tiles = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"},    64'(out_valid), 64'd1);
            check({tag, "_hold_data"},     64'($signed(out_data)), exp_d);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end

        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"},       64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_still_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        cfg_bits   = 4'd0;
        cfg_tiles  = 8'd0;
        cfg_signed = 1'b0;
        in_valid   = 1'b0;
        in_psum    = '0;
        out_ready  = 1'b0;
        #2 rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'($signed(out_data)), 64'd0);
        check("rst_out_sat",   64'(out_sat), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        rst_n = 1'b1;

        q_psum = '{3, 5};
        run_job("unsigned", 2, 1, 0, 0, 0);

        q_psum = '{3, 5};
        run_job("signed", 2, 1, 1, 0, 0);

        q_psum = '{100, -200, 50};
        run_job("bubbles", 1, 3, 0, 2, 0);

        q_psum.delete();
        for (int i = 0; i < 64; i++) q_psum.push_back(32767);
        run_job("sat_pos", 8, 8, 0, 0, 0);

        q_psum.delete();
        for (int i = 0; i < 64; i++) q_psum.push_back(-32768);
        run_job("sat_neg", 8, 8, 0, 0, 0);

        q_psum = '{-1234};
        run_job("zero_cfg", 0, 0, 0, 0, 0);

        q_psum = '{11, -7, 9};
        run_job("backpressure", 3, 1, 1, 0, 5);

        for (int r = 0; r < 8; r++) begin
            int cb;
            int ct;
            int cs;
            cb = int'($urandom_range(0, 15));
            ct = int'($urandom_range(0, 4));
            cs = int'($urandom_range(0, 1));
            q_psum.delete();
            for (int i = 0; i < eff_bits(cb) * eff_tiles(ct); i++)
                q_psum.push_back(int'($signed(16'($urandom))));
            run_job("random", cb, ct, cs, -1, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        start      = 1'b1;
        cfg_bits   = 4'd8;
        cfg_tiles  = 8'd1;
        cfg_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_psum  = 16'sd1000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("abort_in_ready",  64'(in_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data",  64'($signed(out_data)), 64'd0);
        check("abort_out_sat",   64'(out_sat), 64'd0);
        check("abort_busy",      64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        q_psum = '{7};
        run_job("after_abort", 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
